// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream master stage: FSM state encoding and the
// default beat record carried through the skid buffer.
package axis_pkg;

    localparam int AXIS_DATA_W = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } axis_state_e;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic                   last;
    } axis_beat_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry register slice (output register plus one spare entry).
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid never waits on ready, and once valid is high the payload holds
// until it is accepted. in_rdy is a register, so out_rdy has no combinational
// path to in_rdy.
module axis_skid_buf
    import axis_pkg::*;
#(
    parameter type T = axis_beat_t
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic in_vld,
    input  T     in_data,
    output logic in_rdy,
    output logic out_vld,
    output T     out_data,
    input  logic out_rdy
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       rdy_q;
    T           out_q;
    T           spare_q;
    logic       push;
    logic       pop;

    assign push     = in_vld & rdy_q;
    assign pop      = (cnt_q != 2'd0) & out_rdy;
    assign in_rdy   = rdy_q;
    assign out_vld  = (cnt_q != 2'd0);
    assign out_data = out_q;

    // Next occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    // Occupancy and registered ready; ready stays low for the first cycle after reset/clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 2'd0;
            rdy_q <= 1'b0;
        end else if (clear) begin
            cnt_q <= 2'd0;
            rdy_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d <= 2'd1);
        end
    end

    // Data path: the output register refills from the spare first so order is preserved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            spare_q <= '0;
        end else if (clear) begin
            out_q   <= '0;
            spare_q <= '0;
        end else begin
            if (pop) begin
                if (cnt_q == 2'd2) begin
                    out_q <= spare_q;
                end else if (push) begin
                    out_q <= in_data;
                end
            end else if (push && (cnt_q == 2'd0)) begin
                out_q <= in_data;
            end
            if (push && !pop && (cnt_q == 2'd1)) begin
                spare_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/axis_master_stage.sv
// AXI-Stream master stage: pops words from the FIFO read port, tags packet
// ends (programmed length or fifo_last) and drives AXIS through a 2-entry
// skid buffer. Optional macro AXIS_PKT_STATS_EN adds pkt_count/beat_count.
module axis_master_stage
    import axis_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              fifo_rd_vld,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_last,
    output logic              fifo_rd_rdy,
    input  logic [LEN_W-1:0]  pkt_len,
    output logic              m_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              busy,
`ifdef AXIS_PKT_STATS_EN
    output logic [31:0]       pkt_count,
    output logic [31:0]       beat_count,
`endif
    output axis_state_e       state_dbg,
    output logic              pkt_done
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    axis_state_e      state_q;
    axis_state_e      state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] cnt_eff;
    logic             pop;
    logic             last_tag;
    logic             out_hs;
    logic             pkt_done_q;
    beat_t            in_beat;
    beat_t            out_beat;

    assign pop = fifo_rd_vld & fifo_rd_rdy;

    // In IDLE the popped word starts a packet: use the live pkt_len and beat index 0.
    assign len_eff = (state_q == IDLE) ? pkt_len : len_q;
    assign cnt_eff = (state_q == IDLE) ? '0 : cnt_q;

    // Last tag: beat count reaches the programmed length, or fifo_last when length is 0.
    always_comb begin
        last_tag = fifo_last;
        if (len_eff != '0) begin
            last_tag = (cnt_eff == (len_eff - LEN_W'(1)));
        end
    end

    // Next-state: every pop either closes the packet or advances the saturating beat count.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        if (pop) begin
            if (state_q == IDLE) begin
                len_d = pkt_len;
            end
            if (last_tag) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = XFER;
                cnt_d   = (cnt_eff == '1) ? cnt_eff : (cnt_eff + LEN_W'(1));
            end
        end
    end

    // FSM, latched length and beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else if (clear) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_beat.data = fifo_data;
    assign in_beat.last = last_tag;

    axis_skid_buf #(
        .T (beat_t)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_vld   (fifo_rd_vld),
        .in_data  (in_beat),
        .in_rdy   (fifo_rd_rdy),
        .out_vld  (m_axis_tvalid),
        .out_data (out_beat),
        .out_rdy  (m_axis_tready)
    );

    assign m_axis_tdata = out_beat.data;
    assign m_axis_tlast = out_beat.last;
    assign out_hs       = m_axis_tvalid & m_axis_tready;
    assign busy         = (state_q != IDLE) | m_axis_tvalid;
    assign state_dbg    = state_q;
    assign pkt_done     = pkt_done_q;

    // Packet-done pulse on the edge after a tlast beat is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_done_q <= 1'b0;
        end else if (clear) begin
            pkt_done_q <= 1'b0;
        end else begin
            pkt_done_q <= out_hs & out_beat.last;
        end
    end

`ifdef AXIS_PKT_STATS_EN
    // Free-running handshake statistics, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count  <= '0;
            beat_count <= '0;
        end else if (clear) begin
            pkt_count  <= '0;
            beat_count <= '0;
        end else if (out_hs) begin
            beat_count <= beat_count + 32'd1;
            if (out_beat.last) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_master_stage.sv
module tb_axis_master_stage;
    import axis_pkg::*;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              fifo_rd_vld = 1'b0;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              fifo_last = 1'b0;
    logic [LEN_W-1:0]  pkt_len = '0;
    logic              m_axis_tready = 1'b0;
    logic              fifo_rd_rdy;
    logic              m_axis_tvalid;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tlast;
    logic              busy;
    logic              pkt_done;
    axis_state_e       state_dbg;
`ifdef AXIS_PKT_STATS_EN
    logic [31:0]       pkt_count;
    logic [31:0]       beat_count;
`endif

    always #5 clk = ~clk;

    axis_master_stage #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .fifo_rd_vld   (fifo_rd_vld),
        .fifo_data     (fifo_data),
        .fifo_last     (fifo_last),
        .fifo_rd_rdy   (fifo_rd_rdy),
        .pkt_len       (pkt_len),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
`ifdef AXIS_PKT_STATS_EN
        .pkt_count     (pkt_count),
        .beat_count    (beat_count),
`endif
        .state_dbg     (state_dbg),
        .pkt_done      (pkt_done)
    );

    // ---------------- scoreboard ----------------
    logic [DATA_W:0]   exp_q[$];      // {tlast, tdata}
    logic [DATA_W-1:0] src_q[$];
    logic              src_last_q[$];
    int checks = 0;
    int errors = 0;

    // results of the last run_stream call
    int   r_first_hs;
    int   r_last_hs;
    int   r_done_cnt;
    int   r_last_cnt;
    logic r_saw_rdy_low;

    // Source words, expected beats from the packet rules, then a cycle loop that
    // drives FIFO/sink and checks the stream against an occupancy-level model.
    // mode: 0 = tready always 1, 1 = tready random 50%, 2 = tready low for cycles 4..8
    task automatic run_stream(input int n, input int len, input int mode,
                              input int vld_pct, input int budget);
        int popped;
        int hs_n;
        int cyc;
        int occ;
        logic pop;
        logic hs;
        logic prev_stall;
        logic prev_hs_last;
        logic prev_last;
        logic [DATA_W-1:0] prev_data;
        logic [DATA_W-1:0] d;
        logic fl;
        logic [DATA_W:0] exp_beat;
        logic [DATA_W:0] got_beat;

        exp_q.delete();
        src_q.delete();
        src_last_q.delete();
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            if (len == 0) fl = (i == n - 1);
            else          fl = 1'($urandom_range(0, 1));
            src_q.push_back(d);
            src_last_q.push_back(fl);
            exp_beat[DATA_W-1:0] = d;
            exp_beat[DATA_W]     = (len != 0) ? (((i + 1) % len) == 0) : fl;
            exp_q.push_back(exp_beat);
        end

        popped = 0; hs_n = 0; cyc = 0;
        prev_stall = 1'b0; prev_hs_last = 1'b0; prev_last = 1'b0; prev_data = '0;
        r_first_hs = -1; r_last_hs = -1; r_done_cnt = 0; r_last_cnt = 0; r_saw_rdy_low = 1'b0;

        while (((popped < n) || (hs_n < n)) && (cyc < budget)) begin
            @(negedge clk);
            occ = popped - hs_n;
            checks++;
            if (fifo_rd_rdy !== (occ < 2)) begin
                errors++;
                $display("FAIL rd_rdy cyc=%0d: got %b expected %b (occupancy %0d)", cyc, fifo_rd_rdy, (occ < 2), occ);
            end
            checks++;
            if (m_axis_tvalid !== (occ > 0)) begin
                errors++;
                $display("FAIL tvalid cyc=%0d: got %b expected %b", cyc, m_axis_tvalid, (occ > 0));
            end
            checks++;
            if (pkt_done !== prev_hs_last) begin
                errors++;
                $display("FAIL pkt_done cyc=%0d: got %b expected %b", cyc, pkt_done, prev_hs_last);
            end
            if (prev_stall) begin
                checks++;
                if ((m_axis_tdata !== prev_data) || (m_axis_tlast !== prev_last)) begin
                    errors++;
                    $display("FAIL hold cyc=%0d: got %h/%b expected %h/%b", cyc, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
                end
            end
            if (pkt_done === 1'b1) r_done_cnt++;
            if (fifo_rd_rdy === 1'b0) r_saw_rdy_low = 1'b1;

            // drive this cycle's inputs
            fifo_rd_vld = (popped < n) && ($urandom_range(1, 100) <= vld_pct);
            if (popped < n) begin
                fifo_data = src_q[popped];
                fifo_last = src_last_q[popped];
            end
            if ((len != 0) && ((popped % len) != 0)) pkt_len = LEN_W'($urandom_range(1, 15));
            else                                     pkt_len = LEN_W'(len);
            case (mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = !((cyc >= 4) && (cyc < 9));
            endcase

            // predict what the coming edge does
            pop = fifo_rd_vld & fifo_rd_rdy;
            hs  = m_axis_tvalid & m_axis_tready;
            if (hs) begin
                checks++;
                got_beat = {m_axis_tlast, m_axis_tdata};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat cyc=%0d: got %h expected none", cyc, got_beat);
                end else begin
                    exp_beat = exp_q.pop_front();
                    if (got_beat !== exp_beat) begin
                        errors++;
                        $display("FAIL beat %0d: got %h expected %h", hs_n, got_beat, exp_beat);
                    end
                end
                if (m_axis_tlast === 1'b1) r_last_cnt++;
                if (r_first_hs < 0) r_first_hs = cyc;
                r_last_hs = cyc;
                hs_n++;
            end
            if (pop) popped++;
            prev_stall   = m_axis_tvalid & ~m_axis_tready;
            prev_data    = m_axis_tdata;
            prev_last    = m_axis_tlast;
            prev_hs_last = hs & m_axis_tlast;
            cyc++;
        end

        @(negedge clk);
        fifo_rd_vld = 1'b0;
        checks++;
        if ((hs_n != n) || (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL stream_complete: got %0d beats expected %0d (budget %0d)", hs_n, n, budget);
        end
        checks++;
        if (pkt_done !== prev_hs_last) begin
            errors++;
            $display("FAIL pkt_done_final: got %b expected %b", pkt_done, prev_hs_last);
        end
        if (pkt_done === 1'b1) r_done_cnt++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, fifo_rd_rdy, busy, pkt_done} !== 5'b0 || m_axis_tdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v%b l%b r%b b%b d%b data %h expected all 0",
                     m_axis_tvalid, m_axis_tlast, fifo_rd_rdy, busy, pkt_done, m_axis_tdata);
        end
        checks++;
        if (state_dbg !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (fifo_rd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rdy_after_release: got %b expected 0", fifo_rd_rdy);
        end
        @(negedge clk);
        checks++;
        if (fifo_rd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rdy_first_edge: got %b expected 1", fifo_rd_rdy);
        end
    endtask

    task automatic test_len4;
        run_stream(8, 4, 0, 100, 60);
        checks++;
        if (r_done_cnt != 2) begin
            errors++;
            $display("FAIL len4_pkt_done: got %0d pulses expected 2", r_done_cnt);
        end
        checks++;
        if ((r_last_hs - r_first_hs) != 7) begin
            errors++;
            $display("FAIL len4_back_to_back: got span %0d expected 7", r_last_hs - r_first_hs);
        end
    endtask

    task automatic test_fifo_last;
        run_stream(3, 0, 0, 100, 40);
        checks++;
        if (r_last_cnt != 1) begin
            errors++;
            $display("FAIL fifo_last_count: got %0d expected 1", r_last_cnt);
        end
        checks++;
        if ((state_dbg !== IDLE) || (busy !== 1'b0)) begin
            errors++;
            $display("FAIL fifo_last_idle: got state %0d busy %b expected %0d 0", state_dbg, busy, IDLE);
        end
    endtask

    task automatic test_stall;
        run_stream(12, 6, 2, 100, 80);
        checks++;
        if (r_saw_rdy_low !== 1'b1) begin
            errors++;
            $display("FAIL stall_rdy_low: got %b expected 1", r_saw_rdy_low);
        end
    endtask

    task automatic test_random;
        run_stream(1001, 7, 1, 80, 8000);
        checks++;
        if (r_last_cnt != 143) begin
            errors++;
            $display("FAIL random_tlast_count: got %0d expected 143", r_last_cnt);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        pkt_len = LEN_W'(5);
        fifo_rd_vld = 1'b1;
        fifo_data = $urandom;
        fifo_last = 1'b0;
        m_axis_tready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: got tvalid %b expected 1", m_axis_tvalid);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({m_axis_tvalid, busy, fifo_rd_rdy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_async: got v%b b%b r%b expected 000", m_axis_tvalid, busy, fifo_rd_rdy);
        end
        fifo_rd_vld = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_stream(6, 3, 0, 100, 60);
        checks++;
        if (r_last_cnt != 2) begin
            errors++;
            $display("FAIL reset_mid_restart: got %0d tlast beats expected 2", r_last_cnt);
        end
    endtask

    task automatic test_clear;
        @(negedge clk);
        pkt_len = LEN_W'(4);
        fifo_rd_vld = 1'b1;
        fifo_data = $urandom;
        fifo_last = 1'b0;
        m_axis_tready = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        fifo_data = $urandom;
        @(negedge clk);
        checks++;
        if ({m_axis_tvalid, busy, fifo_rd_rdy, pkt_done} !== 4'b0000) begin
            errors++;
            $display("FAIL clear_outputs: got v%b b%b r%b d%b expected 0000", m_axis_tvalid, busy, fifo_rd_rdy, pkt_done);
        end
`ifdef AXIS_PKT_STATS_EN
        checks++;
        if ((pkt_count !== 32'd0) || (beat_count !== 32'd0)) begin
            errors++;
            $display("FAIL clear_stats: got %0d/%0d expected 0/0", pkt_count, beat_count);
        end
`endif
        clear = 1'b0;
        fifo_rd_vld = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk);
        checks++;
        if ({fifo_rd_rdy, m_axis_tvalid} !== 2'b10) begin
            errors++;
            $display("FAIL clear_release: got r%b v%b expected r1 v0", fifo_rd_rdy, m_axis_tvalid);
        end
    endtask

    task automatic test_len1;
        run_stream(10, 1, 1, 100, 200);
        checks++;
        if (r_last_cnt != 10) begin
            errors++;
            $display("FAIL len1_tlast: got %0d expected 10", r_last_cnt);
        end
        checks++;
        if (state_dbg !== IDLE) begin
            errors++;
            $display("FAIL len1_state: got %0d expected %0d", state_dbg, IDLE);
        end
`ifdef AXIS_PKT_STATS_EN
        checks++;
        if ((pkt_count !== 32'd10) || (beat_count !== 32'd10)) begin
            errors++;
            $display("FAIL len1_stats: got %0d/%0d expected 10/10", pkt_count, beat_count);
        end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_len4();
        test_fifo_last();
        test_stall();
        test_random();
        test_reset_mid();
        test_clear();
        test_len1();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
